// File: rtl/core_types_pkg.sv
// Shared core types: datapath width and data-memory responder states.
// Imported by the memory-side blocks of the core.
package core_types_pkg;

  localparam int N_BITS  = 32;
  localparam int N_BYTES = N_BITS / 8;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  function automatic logic [N_BITS-1:0] strb_to_mask(
    input logic [N_BYTES-1:0] strb
  );
    logic [N_BITS-1:0] m;
    m = '0;
    for (int b = 0; b < N_BYTES; b++) begin
      m[8*b +: 8] = {8{strb[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data storage with byte-masked synchronous write
// and registered synchronous read; contents are never reset.
module dmem_array
  import core_types_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic               clk,
  input  logic               we,
  input  logic               re,
  input  logic [AW-1:0]      idx,
  input  logic [N_BITS-1:0]  wdata,
  input  logic [N_BYTES-1:0] wstrb,
  output logic [N_BITS-1:0]  rdata
);

  logic [N_BITS-1:0] mem [DEPTH_WORDS];
  logic [N_BITS-1:0] wmask;

  assign wmask = strb_to_mask(wstrb);

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx] <= (mem[idx] & ~wmask) | (wdata & wmask);
    end
  end

  // Read register only moves on an accepted load, so it doubles as
  // the held response word for the whole response phase.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding request, fixed wait latency,
// held response until the requester takes it, range/alignment faults.
module dmem_responder
  import core_types_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic               req_we,
  input  logic [N_BITS-1:0]  req_addr,
  input  logic [N_BITS-1:0]  req_wdata,
  input  logic [N_BYTES-1:0] req_wstrb,
  output logic               rsp_val,
  input  logic               rsp_rdy,
  output logic [N_BITS-1:0]  rsp_data,
  output logic               rsp_err
);

  localparam int AW =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [N_BITS-1:0] DEPTH_L =
    N_BITS'(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT =
    (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  dmem_state_t state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        err_q, err_n;
  logic        load_q, load_n;

  logic              accept;
  logic              fault;
  logic              wr_en;
  logic              rd_en;
  logic [N_BITS-3:0] word_idx;
  logic [AW-1:0]     mem_idx;
  logic [N_BITS-1:0] rd_word;

  assign word_idx = req_addr[N_BITS-1:2];
  assign mem_idx  = req_addr[2+AW-1:2];

  // Upper address bits only feed the range check, never the index.
  assign fault = (req_addr[1:0] != 2'b00) ||
                 ({2'b00, word_idx} >= DEPTH_L);

  assign req_rdy = (state == IDLE) && !rst;
  assign accept  = req_val && req_rdy;
  assign wr_en   = accept && req_we && !fault;
  assign rd_en   = accept && !req_we && !fault;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .we    (wr_en),
    .re    (rd_en),
    .idx   (mem_idx),
    .wdata (req_wdata),
    .wstrb (req_wstrb),
    .rdata (rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      err_q  <= 1'b0;
      load_q <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      err_q  <= err_n;
      load_q <= load_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = err_q;
    load_n  = load_q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          err_n  = fault;
          load_n = rd_en;
          if (LATENCY == 0) begin
            state_n = RESP;
          end else begin
            state_n = WAIT;
            cnt_n   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_n = RESP;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rsp_val  = (state == RESP);
  assign rsp_err  = err_q;
  assign rsp_data = load_q ? rd_word : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (latency 0, 3, 4) sharing
// request buses, with a queue of expected responses per transaction.
module tb_dmem_responder;
  import core_types_pkg::*;

  localparam int DEPTH = 1024;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_val = 1'b0;
  logic        req_we = 1'b0;
  logic        rsp_rdy = 1'b1;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  int          sel = 0;

  logic [2:0]       rv;
  logic [2:0]       rdy;
  logic [2:0]       vld;
  logic [2:0]       err;
  logic [2:0][31:0] data;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  assign rv[0] = req_val && (sel == 0);
  assign rv[1] = req_val && (sel == 1);
  assign rv[2] = req_val && (sel == 2);

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) u_l0 (
    .clk(clk), .rst(rst), .req_val(rv[0]), .req_rdy(rdy[0]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_val(vld[0]), .rsp_rdy(rsp_rdy),
    .rsp_data(data[0]), .rsp_err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_val(rv[1]), .req_rdy(rdy[1]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_val(vld[1]), .rsp_rdy(rsp_rdy),
    .rsp_data(data[1]), .rsp_err(err[1])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .req_val(rv[2]), .req_rdy(rdy[2]),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb), .rsp_val(vld[2]), .rsp_rdy(rsp_rdy),
    .rsp_data(data[2]), .rsp_err(err[2])
  );

  // Drive a request and hold it until the accept edge.
  task automatic issue(input int u, input logic we,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] s);
    int n;
    n = 0;
    sel = u; req_we = we; req_addr = a;
    req_wdata = wd; req_wstrb = s; req_val = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!rdy[u] && n < 50);
    if (!rdy[u]) begin
      checks++; errors++;
      $display("FAIL accept_timeout u=%0d", u);
    end
    @(posedge clk);
    #1 req_val = 1'b0;
  endtask

  // cyc counts cycles from the accept edge to the first rsp_val.
  task automatic wait_rsp(input int u, output logic [31:0] d,
                          output logic e, output int cyc,
                          output int rdy_hi);
    cyc = 0; rdy_hi = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (rdy[u]) rdy_hi++;
    end while (!vld[u] && cyc < 40);
    if (!vld[u]) begin
      checks++; errors++;
      $display("FAIL rsp_timeout u=%0d", u);
    end
    d = data[u]; e = err[u];
    if (rsp_rdy) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic xact(input int u, input logic we,
                      input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, output logic [31:0] d,
                      output logic e, output int cyc, output int rh);
    issue(u, we, a, wd, s);
    wait_rsp(u, d, e, cyc, rh);
  endtask

  task automatic test_reset();
    rst = 1'b1; rsp_rdy = 1'b1; req_val = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (rdy[u] !== 1'b0 || vld[u] !== 1'b0 ||
          data[u] !== 32'h0 || err[u] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state u=%0d rdy=%b val=%b data=%h err=%b want 0 0 0 0",
                 u, rdy[u], vld[u], data[u], err[u]);
      end
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (rdy[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release_rdy u=%0d got %b want 1", u, rdy[u]);
      end
    end
  endtask

  task automatic test_lat0();
    logic [31:0] d; logic e; int cyc, rh; exp_t x;
    x.data = 32'h0; x.err = 1'b0; sb.push_back(x);
    xact(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, d, e, cyc, rh);
    x = sb.pop_front(); checks++;
    if (d !== x.data || e !== x.err || cyc != 1) begin
      errors++;
      $display("FAIL lat0_store data=%h err=%b cyc=%0d want %h %b 1",
               d, e, cyc, x.data, x.err);
    end
    x.data = 32'hDEADBEEF; x.err = 1'b0; sb.push_back(x);
    xact(0, 1'b0, 32'h10, 32'h0, 4'h0, d, e, cyc, rh);
    x = sb.pop_front(); checks++;
    if (d !== x.data || e !== x.err || cyc != 1) begin
      errors++;
      $display("FAIL lat0_load data=%h err=%b cyc=%0d want %h %b 1",
               d, e, cyc, x.data, x.err);
    end
  endtask

  task automatic test_latency();
    logic [31:0] d; logic e; int cyc, rh; exp_t x;
    x.data = 32'h0; x.err = 1'b0; sb.push_back(x);
    xact(1, 1'b1, 32'h40, 32'h12345678, 4'hF, d, e, cyc, rh);
    x = sb.pop_front(); checks++;
    if (d !== x.data || e !== x.err || cyc != 4 || rh != 0) begin
      errors++;
      $display("FAIL lat3_store data=%h err=%b cyc=%0d rdy_hi=%0d want %h %b 4 0",
               d, e, cyc, rh, x.data, x.err);
    end
    x.data = 32'h12345678; x.err = 1'b0; sb.push_back(x);
    xact(1, 1'b0, 32'h40, 32'h0, 4'h0, d, e, cyc, rh);
    x = sb.pop_front(); checks++;
    if (d !== x.data || e !== x.err || cyc != 4 || rh != 0) begin
      errors++;
      $display("FAIL lat3_load data=%h err=%b cyc=%0d rdy_hi=%0d want %h %b 4 0",
               d, e, cyc, rh, x.data, x.err);
    end
  endtask

  task automatic test_byte_mask();
    logic        we_t [5] = '{1, 1, 0, 1, 0};
    logic [31:0] wd_t [5] = '{32'h11223344, 32'hAABBCCDD, 32'h0,
                              32'hFFFFFFFF, 32'h0};
    logic [3:0]  s_t  [5] = '{4'hF, 4'h5, 4'h0, 4'h0, 4'h0};
    logic [31:0] ex_t [5] = '{32'h0, 32'h0, 32'h11BB33DD,
                              32'h0, 32'h11BB33DD};
    logic [31:0] d; logic e; int cyc, rh; exp_t x;
    for (int i = 0; i < 5; i++) begin
      x.data = ex_t[i]; x.err = 1'b0; sb.push_back(x);
      xact(0, we_t[i], 32'h20, wd_t[i], s_t[i], d, e, cyc, rh);
      x = sb.pop_front(); checks++;
      if (d !== x.data || e !== x.err) begin
        errors++;
        $display("FAIL byte_mask step=%0d data=%h err=%b want %h %b",
                 i, d, e, x.data, x.err);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d, d0; logic e; int cyc, rh; exp_t x;
    rsp_rdy = 1'b0;
    x.data = 32'h12345678; x.err = 1'b0; sb.push_back(x);
    issue(1, 1'b0, 32'h40, 32'h0, 4'h0);
    wait_rsp(1, d, e, cyc, rh);
    d0 = d;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (vld[1] !== 1'b1 || data[1] !== d0 || rdy[1] !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold i=%0d val=%b data=%h rdy=%b want 1 %h 0",
                 i, vld[1], data[1], rdy[1], d0);
      end
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (rdy[1] !== 1'b1 || vld[1] !== 1'b0) begin
      errors++;
      $display("FAIL bp_release rdy=%b val=%b want 1 0", rdy[1], vld[1]);
    end
    x = sb.pop_front(); checks++;
    if (d0 !== x.data || e !== x.err) begin
      errors++;
      $display("FAIL bp_data data=%h err=%b want %h %b", d0, e, x.data, x.err);
    end
  endtask

  task automatic test_faults();
    logic        we_t [4] = '{1, 0, 0, 0};
    logic [31:0] a_t  [4] = '{32'h22, 32'(DEPTH * 4), 32'h21, 32'h20};
    logic [31:0] ex_t [4] = '{32'h0, 32'h0, 32'h0, 32'h11BB33DD};
    logic        er_t [4] = '{1, 1, 1, 0};
    logic [31:0] d; logic e; int cyc, rh; exp_t x;
    for (int i = 0; i < 4; i++) begin
      x.data = ex_t[i]; x.err = er_t[i]; sb.push_back(x);
      xact(0, we_t[i], a_t[i], 32'hFFFFFFFF, 4'hF, d, e, cyc, rh);
      x = sb.pop_front(); checks++;
      if (d !== x.data || e !== x.err || cyc != 1) begin
        errors++;
        $display("FAIL fault step=%0d data=%h err=%b cyc=%0d want %h %b 1",
                 i, d, e, cyc, x.data, x.err);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    logic [31:0] d; logic e; int cyc, rh; exp_t x;
    seen = 1'b0;
    issue(2, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF);
    @(negedge clk); seen |= vld[2];
    @(posedge clk); #1;
    @(negedge clk); seen |= vld[2];
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk); seen |= vld[2];
    checks++;
    if (rdy[2] !== 1'b0) begin
      errors++;
      $display("FAIL rst_rdy_low got %b want 0", rdy[2]);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rdy[2] !== 1'b1) begin
      errors++;
      $display("FAIL rst_rdy_after got %b want 1", rdy[2]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); seen |= vld[2];
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL rst_discard rsp_val seen=%b want 0", seen);
    end
    x.data = 32'hCAFEF00D; x.err = 1'b0; sb.push_back(x);
    xact(2, 1'b0, 32'h30, 32'h0, 4'h0, d, e, cyc, rh);
    x = sb.pop_front(); checks++;
    if (d !== x.data || e !== x.err || cyc != 5) begin
      errors++;
      $display("FAIL rst_store_kept data=%h err=%b cyc=%0d want %h %b 5",
               d, e, cyc, x.data, x.err);
    end
  endtask

  task automatic test_no_bypass();
    int bad;
    bad = 0;
    rsp_rdy = 1'b1;
    sel = 0; req_we = 1'b0; req_addr = 32'h0; req_wstrb = 4'h0;
    @(posedge clk); #1 req_val = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdy[0] === vld[0]) bad++;
    end
    @(posedge clk); #1 req_val = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_bypass overlap_cycles=%0d want 0", bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] mref [8];
    logic [31:0] d, a, wd; logic e, we; int cyc, rh, w; exp_t x;
    logic [3:0] s;
    for (int i = 0; i < 8; i++) begin
      mref[i] = 32'h0101_0101 * (i + 1);
      x.data = 32'h0; x.err = 1'b0; sb.push_back(x);
      xact(0, 1'b1, 32'(i * 4), mref[i], 4'hF, d, e, cyc, rh);
      x = sb.pop_front(); checks++;
      if (d !== x.data || e !== x.err) begin
        errors++;
        $display("FAIL b2b_fill i=%0d data=%h err=%b want %h %b",
                 i, d, e, x.data, x.err);
      end
    end
    for (int i = 0; i < 24; i++) begin
      we = 1'($urandom_range(0, 1));
      w  = int'($urandom_range(0, 7));
      s  = 4'($urandom_range(0, 15));
      wd = $urandom;
      a  = 32'(w * 4);
      if ($urandom_range(0, 5) == 0) a = a + 32'd2;
      x.err  = (a[1:0] != 2'b00);
      x.data = (!we && !x.err) ? mref[w] : 32'h0;
      if (we && !x.err) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mref[w][8*b +: 8] = wd[8*b +: 8];
        end
      end
      sb.push_back(x);
      xact(0, we, a, wd, s, d, e, cyc, rh);
      x = sb.pop_front(); checks++;
      if (d !== x.data || e !== x.err || cyc != 1) begin
        errors++;
        $display("FAIL b2b i=%0d we=%b addr=%h data=%h err=%b cyc=%0d want %h %b 1",
                 i, we, a, d, e, cyc, x.data, x.err);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lat0();
    test_latency();
    test_byte_mask();
    test_backpressure();
    test_faults();
    test_reset_mid_wait();
    test_no_bypass();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, number of N_BITS-wide words of storage.
REQ-002 SHALL have parameter LATENCY, default 1, wait cycles between request accept and response valid (range 0..15).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port req_val, input, 1, request valid from the memory stage.
REQ-006 SHALL have port req_rdy, output, 1, responder can accept a request this cycle.
REQ-007 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, N_BITS, byte address.
REQ-009 SHALL have port req_wdata, input, N_BITS, store data.
REQ-010 SHALL have port req_wstrb, input, N_BITS/8, per-byte write enable.
REQ-011 SHALL have port rsp_val, output, 1, response valid.
REQ-012 SHALL have port rsp_rdy, input, 1, requester accepts response.
REQ-013 SHALL have port rsp_data, output, N_BITS, load data; drives the memory stage mem_rsp_data.
REQ-014 SHALL have port rsp_err, output, 1, access fault flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_rdy = 1 only in IDLE with rst low; rsp_val = 1 only in RESP.
REQ-017 SHALL accept a request on a cycle with req_val && req_rdy; one outstanding request maximum.
REQ-018 On accept with LATENCY = 0, SHALL go IDLE -> RESP; rsp_val rises the next cycle.
REQ-019 On accept with LATENCY > 0, SHALL go IDLE -> WAIT, load the wait counter with LATENCY-1, and decrement it each cycle.
REQ-020 SHALL go WAIT -> RESP when the counter is 0, so rsp_val rises exactly LATENCY+1 cycles after the accept edge.
REQ-021 SHALL hold rsp_val, rsp_data and rsp_err stable in RESP until rsp_rdy; on rsp_val && rsp_rdy, go RESP -> IDLE.
REQ-022 SHALL never accept a new request in the same cycle as a response handshake (no bypass); the first re-accept is one cycle later.
REQ-023 Fault condition: req_addr[1:0] != 0 or word index req_addr[N_BITS-1:2] >= DEPTH_WORDS.
REQ-024 Store without fault: SHALL write only the bytes with req_wstrb set, at the accept edge; rsp_data = 0, rsp_err = 0.
REQ-025 Load without fault: SHALL capture the word at the accept edge into the response register; rsp_data = that word, rsp_err = 0.
REQ-026 Faulting access: SHALL perform no write; rsp_data = 0, rsp_err = 1; response timing identical to non-faulting accesses.
REQ-027 A store with req_wstrb = 0 SHALL leave memory unchanged and still produce a normal response.
REQ-028 Storage index SHALL be req_addr[2+$clog2(DEPTH_WORDS)-1:2]; upper address bits are used only in the range check.
REQ-029 req_val deasserting while req_rdy = 0 SHALL have no effect; there is no request abort.

Reset
REQ-030 Reset SHALL set state = IDLE, wait counter = 0, rsp_val = 0, rsp_data = 0, rsp_err = 0, and req_rdy = 0 while rst is high.
REQ-031 Reset asserted in WAIT or RESP SHALL discard the in-flight response; a store already written SHALL remain written.
REQ-032 Storage contents SHALL NOT be reset.

Structure
REQ-033 core_types_pkg SHALL hold N_BITS and a dmem_state_t enum (IDLE, WAIT, RESP); requests SHALL use discrete ports, not a struct.
REQ-034 Storage SHALL be a sub-module dmem_array (DEPTH_WORDS x N_BITS, synchronous byte-masked write, synchronous read, no reset); FSM, counter and response register live in dmem_responder.

Verification
REQ-035 LATENCY = 0: store 0xDEADBEEF to addr 0x10, wstrb 0xF, rsp_rdy = 1 -> rsp_val on cycle+1, rsp_err = 0; subsequent load of 0x10 -> rsp_data = 0xDEADBEEF.
REQ-036 LATENCY = 3: load accepted at cycle T -> rsp_val first high at T+4; req_rdy low for T+1 through T+4.
REQ-037 Byte masking: word 0x11223344 at 0x20, then store 0xAABBCCDD with wstrb 0x5 -> load of 0x20 returns 0x11BB33DD.
REQ-038 Backpressure: rsp_rdy held low 5 cycles -> rsp_val and rsp_data stable for the whole hold; req_rdy rises one cycle after the handshake.
REQ-039 Faults: store to 0x22, and load of DEPTH_WORDS*4 -> rsp_err = 1, rsp_data = 0; memory unchanged, verified by read-back.
REQ-040 Reset mid-WAIT (LATENCY = 4, rst asserted 2 cycles after accept) -> rsp_val never asserts; req_rdy = 1 the cycle after rst falls.
